pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the 14-bit-instruction core. It replaces the free-running 13-bit counter with a block that supports sequential fetch, skip, GOTO, CALL and RETURN/RETLW, backed by a circular hardware return stack. It sits between the instruction decoder and the instruction memory address port. It advances only when the core's phase enable is high.

---
 rtl/pc_sequencer.sv | 130 +++++++++++++
 tb/tb_pc_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential fetch, skip, GOTO, CALL and RET
// with a circular return stack and sticky overflow/underflow flags.
module pc_sequencer #(
    parameter int unsigned PC_W        = 13,
    parameter int unsigned STACK_DEPTH = 8,
    parameter int unsigned RESET_VEC   = 0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               advance,
    input  logic [2:0]                         op,
    input  logic [PC_W-1:0]                    target,
    input  logic                               flag_clr,
    output logic [PC_W-1:0]                    pc,
    output logic                               flush,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_level,
    output logic                               stack_overflow,
    output logic                               stack_underflow
);

    localparam int unsigned PTR_W = $clog2(STACK_DEPTH);
    localparam int unsigned LVL_W = $clog2(STACK_DEPTH + 1);

    typedef enum logic [2:0] {
        OP_NEXT = 3'd0,
        OP_SKIP = 3'd1,
        OP_GOTO = 3'd2,
        OP_CALL = 3'd3,
        OP_RET  = 3'd4
    } op_e;

    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [LVL_W-1:0] lvl_q, lvl_d;
    logic             flush_q, flush_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             push_en;
    logic [PC_W-1:0]  stack_q [STACK_DEPTH];

    logic [PC_W-1:0]  pc_inc;
    logic [PTR_W-1:0] ptr_dec;

    assign pc_inc  = pc_q + PC_W'(1);
    // Pointer width equals log2(depth), so natural wrap gives the circular index.
    assign ptr_dec = ptr_q - PTR_W'(1);

    // advance is a plain enable: an op is consumed on every rising edge where
    // advance=1; there is no back-pressure and no acknowledge.
    always_comb begin
        pc_d    = pc_q;
        ptr_d   = ptr_q;
        lvl_d   = lvl_q;
        flush_d = 1'b0;
        ovf_d   = ovf_q & ~flag_clr;
        unf_d   = unf_q & ~flag_clr;
        push_en = 1'b0;
        if (advance) begin
            case (op_e'(op))
                OP_SKIP: begin
                    pc_d    = pc_q + PC_W'(2);
                    flush_d = 1'b1;
                end
                OP_GOTO: begin
                    pc_d    = target;
                    flush_d = 1'b1;
                end
                OP_CALL: begin
                    push_en = 1'b1;
                    ptr_d   = ptr_q + PTR_W'(1);
                    pc_d    = target;
                    flush_d = 1'b1;
                    if (lvl_q == LVL_W'(STACK_DEPTH)) begin
                        ovf_d = 1'b1;
                    end else begin
                        lvl_d = lvl_q + LVL_W'(1);
                    end
                end
                OP_RET: begin
                    ptr_d   = ptr_dec;
                    pc_d    = stack_q[ptr_dec];
                    flush_d = 1'b1;
                    if (lvl_q == '0) begin
                        unf_d = 1'b1;
                    end else begin
                        lvl_d = lvl_q - LVL_W'(1);
                    end
                end
                default: begin
                    pc_d = pc_inc;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= PC_W'(RESET_VEC);
            ptr_q   <= '0;
            lvl_q   <= '0;
            flush_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ptr_q   <= ptr_d;
            lvl_q   <= lvl_d;
            flush_q <= flush_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else if (push_en) begin
            stack_q[ptr_q] <= pc_inc;
        end
    end

    assign pc              = pc_q;
    assign flush           = flush_q;
    assign stack_level     = lvl_q;
    assign stack_overflow  = ovf_q;
    assign stack_underflow = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: driver pushes expected post-edge state,
// monitor pops and compares one entry per rising edge.
module tb_pc_sequencer;

    localparam int unsigned PC_W  = 13;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    localparam logic [2:0] NEXT = 3'd0;
    localparam logic [2:0] SKIP = 3'd1;
    localparam logic [2:0] GOTO = 3'd2;
    localparam logic [2:0] CALL = 3'd3;
    localparam logic [2:0] RET  = 3'd4;

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic             flush;
        logic [LVL_W-1:0] lvl;
        logic             ovf;
        logic             unf;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             advance;
    logic [2:0]       op;
    logic [PC_W-1:0]  target;
    logic             flag_clr;
    logic [PC_W-1:0]  pc;
    logic             flush;
    logic [LVL_W-1:0] stack_level;
    logic             stack_overflow;
    logic             stack_underflow;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    pc_sequencer #(.PC_W(PC_W), .STACK_DEPTH(DEPTH), .RESET_VEC(0)) dut (
        .clk             (clk),
        .reset           (reset),
        .advance         (advance),
        .op              (op),
        .target          (target),
        .flag_clr        (flag_clr),
        .pc              (pc),
        .flush           (flush),
        .stack_level     (stack_level),
        .stack_overflow  (stack_overflow),
        .stack_underflow (stack_underflow)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver: apply one cycle of inputs and queue the expected post-edge state.
    task automatic step(input logic rst, input logic adv, input logic [2:0] o,
                        input logic [PC_W-1:0] tgt, input logic clr,
                        input logic [PC_W-1:0] e_pc, input logic e_flush,
                        input int e_lvl, input logic e_ovf, input logic e_unf);
        exp_t e;
        @(negedge clk);
        reset    = rst;
        advance  = adv;
        op       = o;
        target   = tgt;
        flag_clr = clr;
        e.pc     = e_pc;
        e.flush  = e_flush;
        e.lvl    = LVL_W'(e_lvl);
        e.ovf    = e_ovf;
        e.unf    = e_unf;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc", int'(pc), int'(e.pc));
                chk("flush", int'(flush), int'(e.flush));
                chk("stack_level", int'(stack_level), int'(e.lvl));
                chk("stack_overflow", int'(stack_overflow), int'(e.ovf));
                chk("stack_underflow", int'(stack_underflow), int'(e.unf));
            end
        end
    end

    initial begin
        reset    = 1'b1;
        advance  = 1'b0;
        op       = NEXT;
        target   = '0;
        flag_clr = 1'b0;

        // Reset then sequential fetch and hold
        step(1, 0, NEXT, 0, 0, 13'h0000, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++)
            step(0, 1, NEXT, 0, 0, PC_W'(i), 0, 0, 0, 0);
        step(0, 0, NEXT, 0, 0, 13'h0005, 0, 0, 0, 0);
        step(0, 0, GOTO, 13'h0AAA, 0, 13'h0005, 0, 0, 0, 0);
        step(0, 1, 3'd6, 0, 0, 13'h0006, 0, 0, 0, 0);

        // Wrap-around
        step(0, 1, GOTO, 13'h1FFF, 0, 13'h1FFF, 1, 0, 0, 0);
        step(0, 1, NEXT, 0, 0, 13'h0000, 0, 0, 0, 0);
        step(0, 1, GOTO, 13'h1FFE, 0, 13'h1FFE, 1, 0, 0, 0);
        step(0, 0, NEXT, 0, 0, 13'h1FFE, 0, 0, 0, 0);
        step(0, 1, SKIP, 0, 0, 13'h0000, 1, 0, 0, 0);
        step(0, 1, NEXT, 0, 0, 13'h0001, 0, 0, 0, 0);

        // Single call / return
        step(0, 1, GOTO, 13'h0010, 0, 13'h0010, 1, 0, 0, 0);
        step(0, 1, CALL, 13'h0200, 0, 13'h0200, 1, 1, 0, 0);
        step(0, 1, NEXT, 0, 0, 13'h0201, 0, 1, 0, 0);
        step(0, 1, RET, 0, 0, 13'h0011, 1, 0, 0, 0);

        // Nine nested calls: the ninth overwrites the first entry
        for (int n = 0; n <= 8; n++)
            step(0, 1, CALL, PC_W'(13'h100 + n), 0, PC_W'(13'h100 + n), 1,
                 (n + 1 > 8) ? 8 : n + 1, (n == 8), 0);
        for (int k = 1; k <= 8; k++)
            step(0, 1, RET, 0, 0, PC_W'(13'h109 - k), 1, 8 - k, 1, 0);
        step(0, 1, NEXT, 0, 1, 13'h0102, 0, 0, 0, 0);

        // Underflow and flag clear priority
        step(1, 1, NEXT, 0, 0, 13'h0000, 0, 0, 0, 0);
        step(0, 1, RET, 0, 0, 13'h0000, 1, 0, 0, 1);
        step(0, 1, NEXT, 0, 1, 13'h0001, 0, 0, 0, 0);
        step(0, 1, RET, 0, 0, 13'h0000, 1, 0, 0, 1);
        step(0, 1, RET, 0, 1, 13'h0000, 1, 0, 0, 1);
        step(0, 1, NEXT, 0, 0, 13'h0001, 0, 0, 0, 1);

        // Reset in the middle of a call chain
        step(1, 0, NEXT, 0, 0, 13'h0000, 0, 0, 0, 0);
        step(0, 1, CALL, 13'h0100, 0, 13'h0100, 1, 1, 0, 0);
        step(0, 1, CALL, 13'h0200, 0, 13'h0200, 1, 2, 0, 0);
        step(0, 1, CALL, 13'h0345, 0, 13'h0345, 1, 3, 0, 0);
        step(1, 1, CALL, 13'h0777, 0, 13'h0000, 0, 0, 0, 0);
        step(0, 1, GOTO, 13'h0020, 0, 13'h0020, 1, 0, 0, 0);
        step(0, 1, RET, 0, 0, 13'h0000, 1, 0, 0, 1);

        @(negedge clk);
        reset   = 1'b0;
        advance = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
